// File: rtl/internal_ram_arbiter.sv
// Shares one single-port 2048x64 on-chip RAM between a critical-word-first
// instruction-fetch burst port (A) and a single-beat masked read/write data port (B).
module internal_ram_arbiter #(
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_cmd_valid,
    output logic        a_cmd_ready,
    input  logic [10:0] a_cmd_addr,
    output logic        a_rsp_valid,
    output logic [63:0] a_rsp_data,
    output logic        a_rsp_last,
    input  logic        b_cmd_valid,
    output logic        b_cmd_ready,
    input  logic        b_cmd_write,
    input  logic [10:0] b_cmd_addr,
    input  logic [7:0]  b_cmd_mask,
    input  logic [63:0] b_cmd_data,
    output logic        b_rsp_valid,
    output logic [63:0] b_rsp_data,
    output logic        b_rsp_error,
    output logic        ram_en,
    output logic        ram_wr,
    output logic [10:0] ram_addr,
    output logic [7:0]  ram_mask,
    output logic [63:0] ram_wrData,
    input  logic [63:0] ram_rdData
);

    localparam int K = $clog2(LINE_WORDS);
    localparam logic [K-1:0] BEAT_ONE  = K'(1);
    localparam logic [K-1:0] BEAT_LAST = K'(LINE_WORDS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t      state_q;
    logic [K-1:0] beat_q;
    logic [10:0] burst_base_q;
    logic        last_grant_q;   // 1'b1 = B was granted most recently
    logic        a_rsp_valid_q;
    logic        a_rsp_last_q;
    logic        b_rsp_valid_q;
    logic        b_rsp_error_q;

    logic        idle_s;
    logic        burst_s;
    logic        grant_a_s;
    logic        grant_b_s;
    logic        rom_write_s;
    logic [K-1:0] burst_off_s;
    logic [10:0] burst_addr_s;

    // Round-robin grant decision; nothing is granted while reset is held.
    always_comb begin
        idle_s       = (state_q == ST_IDLE) && !reset;
        burst_s      = (state_q == ST_BURST) && !reset;
        grant_a_s    = idle_s && a_cmd_valid && (!b_cmd_valid || last_grant_q);
        grant_b_s    = idle_s && b_cmd_valid && (!a_cmd_valid || !last_grant_q);
        rom_write_s  = b_cmd_write && !b_cmd_addr[10];
        burst_off_s  = burst_base_q[K-1:0] + beat_q;
        burst_addr_s = {burst_base_q[10:K], burst_off_s};
        a_cmd_ready  = grant_a_s;
        b_cmd_ready  = grant_b_s;
    end

    // RAM command mux: burst beats, then A acceptance, then B read / legal write.
    always_comb begin
        ram_en     = 1'b0;
        ram_wr     = 1'b0;
        ram_addr   = 11'h000;
        ram_mask   = 8'h00;
        ram_wrData = 64'h0;
        if (burst_s) begin
            ram_en   = 1'b1;
            ram_addr = burst_addr_s;
        end else if (grant_a_s) begin
            ram_en   = 1'b1;
            ram_addr = a_cmd_addr;
        end else if (grant_b_s && !b_cmd_write) begin
            ram_en   = 1'b1;
            ram_addr = b_cmd_addr;
        end else if (grant_b_s && !rom_write_s) begin
            ram_en     = 1'b1;
            ram_wr     = 1'b1;
            ram_addr   = b_cmd_addr;
            ram_mask   = b_cmd_mask;
            ram_wrData = b_cmd_data;
        end else begin
            ram_en = 1'b0;
        end
    end

    // Sequencer state and registered response flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            beat_q        <= '0;
            burst_base_q  <= 11'h000;
            last_grant_q  <= 1'b1;
            a_rsp_valid_q <= 1'b0;
            a_rsp_last_q  <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            b_rsp_error_q <= 1'b0;
        end else begin
            a_rsp_valid_q <= grant_a_s || burst_s;
            a_rsp_last_q  <= burst_s && (beat_q == BEAT_LAST);
            b_rsp_valid_q <= grant_b_s;
            b_rsp_error_q <= grant_b_s && rom_write_s;
            case (state_q)
                ST_IDLE: begin
                    if (grant_a_s) begin
                        state_q      <= ST_BURST;
                        beat_q       <= BEAT_ONE;
                        burst_base_q <= a_cmd_addr;
                        last_grant_q <= 1'b0;
                    end else if (grant_b_s) begin
                        last_grant_q <= 1'b1;
                    end else begin
                        last_grant_q <= last_grant_q;
                    end
                end
                ST_BURST: begin
                    if (beat_q == BEAT_LAST) begin
                        state_q <= ST_IDLE;
                        beat_q  <= '0;
                    end else begin
                        beat_q <= beat_q + BEAT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    beat_q  <= '0;
                end
            endcase
        end
    end

    assign a_rsp_valid = a_rsp_valid_q;
    assign a_rsp_last  = a_rsp_last_q;
    assign b_rsp_valid = b_rsp_valid_q;
    assign b_rsp_error = b_rsp_error_q;
    assign a_rsp_data  = ram_rdData;
    assign b_rsp_data  = ram_rdData;

endmodule

// File: tb/tb_internal_ram_arbiter.sv
// Directed table-driven bench for internal_ram_arbiter with a behavioural RAM
// preloaded from a known address pattern.
module tb_internal_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_cmd_valid, a_cmd_ready, a_rsp_valid, a_rsp_last;
    logic [10:0] a_cmd_addr;
    logic [63:0] a_rsp_data;
    logic        b_cmd_valid, b_cmd_ready, b_cmd_write, b_rsp_valid, b_rsp_error;
    logic [10:0] b_cmd_addr;
    logic [7:0]  b_cmd_mask;
    logic [63:0] b_cmd_data, b_rsp_data;
    logic        ram_en, ram_wr;
    logic [10:0] ram_addr;
    logic [7:0]  ram_mask;
    logic [63:0] ram_wrData, ram_rdData;

    int checks = 0;
    int failures = 0;

    internal_ram_arbiter #(.LINE_WORDS(4)) dut (
        .clk(clk), .reset(reset),
        .a_cmd_valid(a_cmd_valid), .a_cmd_ready(a_cmd_ready), .a_cmd_addr(a_cmd_addr),
        .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data), .a_rsp_last(a_rsp_last),
        .b_cmd_valid(b_cmd_valid), .b_cmd_ready(b_cmd_ready), .b_cmd_write(b_cmd_write),
        .b_cmd_addr(b_cmd_addr), .b_cmd_mask(b_cmd_mask), .b_cmd_data(b_cmd_data),
        .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data), .b_rsp_error(b_rsp_error),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_mask(ram_mask),
        .ram_wrData(ram_wrData), .ram_rdData(ram_rdData)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mv(input logic [10:0] a);
        return {16'hC0DE, 5'd0, a, 16'hF00D, 5'd0, a};
    endfunction

    // Behavioural single-port RAM, one-cycle read latency.
    logic [63:0] mem [0:2047];
    logic [63:0] rd_q = 64'h0;
    initial for (int i = 0; i < 2048; i++) mem[i] = mv(11'(i));
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) begin
                for (int j = 0; j < 8; j++)
                    if (ram_mask[j]) mem[ram_addr][8*j +: 8] <= ram_wrData[8*j +: 8];
            end
            rd_q <= mem[ram_addr];
        end
    end
    assign ram_rdData = rd_q;

    typedef struct {
        logic        av;  logic [10:0] aa;
        logic        bv;  logic bw; logic [10:0] ba; logic [7:0] bm; logic [63:0] bd;
        logic        ardy; logic brdy; logic en; logic wr; logic [10:0] addr; logic [7:0] mask;
        logic        arv; logic alast; logic brv; logic berr;
        logic [1:0]  dsel; logic [63:0] dexp;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(
        input logic av, input logic [10:0] aa,
        input logic bv, input logic bw, input logic [10:0] ba, input logic [7:0] bm,
        input logic [63:0] bd,
        input logic ardy, input logic brdy, input logic en, input logic wr,
        input logic [10:0] addr, input logic [7:0] mask,
        input logic arv, input logic alast, input logic brv, input logic berr,
        input logic [1:0] dsel, input logic [63:0] dexp);
        vec_t r;
        r.av = av; r.aa = aa; r.bv = bv; r.bw = bw; r.ba = ba; r.bm = bm; r.bd = bd;
        r.ardy = ardy; r.brdy = brdy; r.en = en; r.wr = wr; r.addr = addr; r.mask = mask;
        r.arv = arv; r.alast = alast; r.brv = brv; r.berr = berr; r.dsel = dsel; r.dexp = dexp;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        a_cmd_valid = 1'b0; a_cmd_addr = 11'h000;
        b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_addr = 11'h000;
        b_cmd_mask = 8'h00; b_cmd_data = 64'h0;
    endtask

    initial begin
        // A burst with wrap, B masked write/read-back, ROM-write error
        vt.push_back(v(1'b1,11'h402, 1'b0,1'b0,11'h000,8'h00,64'h0, 1'b1,1'b0,1'b1,1'b0,11'h402,8'h00, 1'b0,1'b0,1'b0,1'b0, 2'd0,64'h0));
        vt.push_back(v(1'b0,11'h000, 1'b0,1'b0,11'h000,8'h00,64'h0, 1'b0,1'b0,1'b1,1'b0,11'h403,8'h00, 1'b1,1'b0,1'b0,1'b0, 2'd1,mv(11'h402)));
        vt.push_back(v(1'b0,11'h000, 1'b0,1'b0,11'h000,8'h00,64'h0, 1'b0,1'b0,1'b1,1'b0,11'h400,8'h00, 1'b1,1'b0,1'b0,1'b0, 2'd1,mv(11'h403)));
        vt.push_back(v(1'b0,11'h000, 1'b0,1'b0,11'h000,8'h00,64'h0, 1'b0,1'b0,1'b1,1'b0,11'h401,8'h00, 1'b1,1'b0,1'b0,1'b0, 2'd1,mv(11'h400)));
        vt.push_back(v(1'b0,11'h000, 1'b0,1'b0,11'h000,8'h00,64'h0, 1'b0,1'b0,1'b0,1'b0,11'h000,8'h00, 1'b1,1'b1,1'b0,1'b0, 2'd1,mv(11'h401)));
        vt.push_back(v(1'b0,11'h000, 1'b1,1'b1,11'h500,8'h0F,64'h1122334455667788, 1'b0,1'b1,1'b1,1'b1,11'h500,8'h0F, 1'b0,1'b0,1'b0,1'b0, 2'd0,64'h0));
        vt.push_back(v(1'b0,11'h000, 1'b1,1'b0,11'h500,8'h00,64'h0, 1'b0,1'b1,1'b1,1'b0,11'h500,8'h00, 1'b0,1'b0,1'b1,1'b0, 2'd0,64'h0));
        vt.push_back(v(1'b0,11'h000, 1'b0,1'b0,11'h000,8'h00,64'h0, 1'b0,1'b0,1'b0,1'b0,11'h000,8'h00, 1'b0,1'b0,1'b1,1'b0, 2'd2,64'hC0DE0500_55667788));
        vt.push_back(v(1'b0,11'h000, 1'b1,1'b1,11'h010,8'hFF,64'hDEADBEEFDEADBEEF, 1'b0,1'b1,1'b0,1'b0,11'h000,8'h00, 1'b0,1'b0,1'b0,1'b0, 2'd0,64'h0));
        vt.push_back(v(1'b0,11'h000, 1'b0,1'b0,11'h000,8'h00,64'h0, 1'b0,1'b0,1'b0,1'b0,11'h000,8'h00, 1'b0,1'b0,1'b1,1'b1, 2'd0,64'h0));
        // Simultaneous requests: grants alternate A, B, A, B, A, B
        vt.push_back(v(1'b1,11'h040, 1'b1,1'b0,11'h123,8'h00,64'h0, 1'b1,1'b0,1'b1,1'b0,11'h040,8'h00, 1'b0,1'b0,1'b0,1'b0, 2'd0,64'h0));
        vt.push_back(v(1'b1,11'h081, 1'b1,1'b0,11'h123,8'h00,64'h0, 1'b0,1'b0,1'b1,1'b0,11'h041,8'h00, 1'b1,1'b0,1'b0,1'b0, 2'd1,mv(11'h040)));
        vt.push_back(v(1'b1,11'h081, 1'b1,1'b0,11'h123,8'h00,64'h0, 1'b0,1'b0,1'b1,1'b0,11'h042,8'h00, 1'b1,1'b0,1'b0,1'b0, 2'd1,mv(11'h041)));
        vt.push_back(v(1'b1,11'h081, 1'b1,1'b0,11'h123,8'h00,64'h0, 1'b0,1'b0,1'b1,1'b0,11'h043,8'h00, 1'b1,1'b0,1'b0,1'b0, 2'd1,mv(11'h042)));
        vt.push_back(v(1'b1,11'h081, 1'b1,1'b0,11'h123,8'h00,64'h0, 1'b0,1'b1,1'b1,1'b0,11'h123,8'h00, 1'b1,1'b1,1'b0,1'b0, 2'd1,mv(11'h043)));
        vt.push_back(v(1'b1,11'h081, 1'b1,1'b0,11'h124,8'h00,64'h0, 1'b1,1'b0,1'b1,1'b0,11'h081,8'h00, 1'b0,1'b0,1'b1,1'b0, 2'd2,mv(11'h123)));
        vt.push_back(v(1'b1,11'h0C0, 1'b1,1'b0,11'h124,8'h00,64'h0, 1'b0,1'b0,1'b1,1'b0,11'h082,8'h00, 1'b1,1'b0,1'b0,1'b0, 2'd1,mv(11'h081)));
        vt.push_back(v(1'b1,11'h0C0, 1'b1,1'b0,11'h124,8'h00,64'h0, 1'b0,1'b0,1'b1,1'b0,11'h083,8'h00, 1'b1,1'b0,1'b0,1'b0, 2'd1,mv(11'h082)));
        vt.push_back(v(1'b1,11'h0C0, 1'b1,1'b0,11'h124,8'h00,64'h0, 1'b0,1'b0,1'b1,1'b0,11'h080,8'h00, 1'b1,1'b0,1'b0,1'b0, 2'd1,mv(11'h083)));
        vt.push_back(v(1'b1,11'h0C0, 1'b1,1'b0,11'h124,8'h00,64'h0, 1'b0,1'b1,1'b1,1'b0,11'h124,8'h00, 1'b1,1'b1,1'b0,1'b0, 2'd1,mv(11'h080)));
        vt.push_back(v(1'b1,11'h0C0, 1'b1,1'b0,11'h125,8'h00,64'h0, 1'b1,1'b0,1'b1,1'b0,11'h0C0,8'h00, 1'b0,1'b0,1'b1,1'b0, 2'd2,mv(11'h124)));
        vt.push_back(v(1'b0,11'h000, 1'b1,1'b0,11'h125,8'h00,64'h0, 1'b0,1'b0,1'b1,1'b0,11'h0C1,8'h00, 1'b1,1'b0,1'b0,1'b0, 2'd1,mv(11'h0C0)));
        vt.push_back(v(1'b0,11'h000, 1'b1,1'b0,11'h125,8'h00,64'h0, 1'b0,1'b0,1'b1,1'b0,11'h0C2,8'h00, 1'b1,1'b0,1'b0,1'b0, 2'd1,mv(11'h0C1)));
        vt.push_back(v(1'b0,11'h000, 1'b1,1'b0,11'h125,8'h00,64'h0, 1'b0,1'b0,1'b1,1'b0,11'h0C3,8'h00, 1'b1,1'b0,1'b0,1'b0, 2'd1,mv(11'h0C2)));
        vt.push_back(v(1'b0,11'h000, 1'b1,1'b0,11'h125,8'h00,64'h0, 1'b0,1'b1,1'b1,1'b0,11'h125,8'h00, 1'b1,1'b1,1'b0,1'b0, 2'd1,mv(11'h0C3)));
        // Back-to-back B reads of ROM with A idle
        vt.push_back(v(1'b0,11'h000, 1'b1,1'b0,11'h000,8'h00,64'h0, 1'b0,1'b1,1'b1,1'b0,11'h000,8'h00, 1'b0,1'b0,1'b1,1'b0, 2'd2,mv(11'h125)));
        vt.push_back(v(1'b0,11'h000, 1'b1,1'b0,11'h001,8'h00,64'h0, 1'b0,1'b1,1'b1,1'b0,11'h001,8'h00, 1'b0,1'b0,1'b1,1'b0, 2'd2,mv(11'h000)));
        vt.push_back(v(1'b0,11'h000, 1'b1,1'b0,11'h002,8'h00,64'h0, 1'b0,1'b1,1'b1,1'b0,11'h002,8'h00, 1'b0,1'b0,1'b1,1'b0, 2'd2,mv(11'h001)));
        vt.push_back(v(1'b0,11'h000, 1'b1,1'b0,11'h003,8'h00,64'h0, 1'b0,1'b1,1'b1,1'b0,11'h003,8'h00, 1'b0,1'b0,1'b1,1'b0, 2'd2,mv(11'h002)));
        vt.push_back(v(1'b0,11'h000, 1'b0,1'b0,11'h000,8'h00,64'h0, 1'b0,1'b0,1'b0,1'b0,11'h000,8'h00, 1'b0,1'b0,1'b1,1'b0, 2'd2,mv(11'h003)));

        // Reset with both ports requesting: no grant, no RAM access, flags clear
        reset = 1'b1;
        drive_idle();
        a_cmd_valid = 1'b1; a_cmd_addr = 11'h402;
        b_cmd_valid = 1'b1; b_cmd_write = 1'b1; b_cmd_addr = 11'h500; b_cmd_mask = 8'hFF;
        repeat (2) @(negedge clk);
        #1;
        chk("rst ram_en", 64'(ram_en), 64'h0);
        chk("rst ram_wr", 64'(ram_wr), 64'h0);
        chk("rst a_ready", 64'(a_cmd_ready), 64'h0);
        chk("rst b_ready", 64'(b_cmd_ready), 64'h0);
        chk("rst a_rsp_valid", 64'(a_rsp_valid), 64'h0);
        chk("rst a_rsp_last", 64'(a_rsp_last), 64'h0);
        chk("rst b_rsp_valid", 64'(b_rsp_valid), 64'h0);
        chk("rst b_rsp_error", 64'(b_rsp_error), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            if (i != 0) @(negedge clk);
            a_cmd_valid = vt[i].av; a_cmd_addr = vt[i].aa;
            b_cmd_valid = vt[i].bv; b_cmd_write = vt[i].bw; b_cmd_addr = vt[i].ba;
            b_cmd_mask = vt[i].bm; b_cmd_data = vt[i].bd;
            #1;
            chk($sformatf("r%0d a_ready", i), 64'(a_cmd_ready), 64'(vt[i].ardy));
            chk($sformatf("r%0d b_ready", i), 64'(b_cmd_ready), 64'(vt[i].brdy));
            chk($sformatf("r%0d ram_en", i), 64'(ram_en), 64'(vt[i].en));
            chk($sformatf("r%0d ram_wr", i), 64'(ram_wr), 64'(vt[i].wr));
            if (vt[i].en) begin
                chk($sformatf("r%0d ram_addr", i), 64'(ram_addr), 64'(vt[i].addr));
                chk($sformatf("r%0d ram_mask", i), 64'(ram_mask), 64'(vt[i].mask));
                if (vt[i].wr) chk($sformatf("r%0d ram_wrData", i), ram_wrData, vt[i].bd);
            end
            chk($sformatf("r%0d a_rsp_valid", i), 64'(a_rsp_valid), 64'(vt[i].arv));
            chk($sformatf("r%0d a_rsp_last", i), 64'(a_rsp_last), 64'(vt[i].alast));
            chk($sformatf("r%0d b_rsp_valid", i), 64'(b_rsp_valid), 64'(vt[i].brv));
            chk($sformatf("r%0d b_rsp_error", i), 64'(b_rsp_error), 64'(vt[i].berr));
            if (vt[i].dsel == 2'd1) chk($sformatf("r%0d a_rsp_data", i), a_rsp_data, vt[i].dexp);
            if (vt[i].dsel == 2'd2) chk($sformatf("r%0d b_rsp_data", i), b_rsp_data, vt[i].dexp);
        end

        // Reset during beat 2 of a burst drops the remaining beats
        @(negedge clk);
        drive_idle();
        a_cmd_valid = 1'b1; a_cmd_addr = 11'h402;
        #1;
        chk("mr accept", 64'(a_cmd_ready), 64'h1);
        @(negedge clk);
        a_cmd_valid = 1'b0;
        #1;
        chk("mr beat1 addr", 64'(ram_addr), 64'h403);
        @(negedge clk);
        #1;
        chk("mr beat2 addr", 64'(ram_addr), 64'h400);
        chk("mr beat2 a_rsp_valid", 64'(a_rsp_valid), 64'h1);
        reset = 1'b1;
        #1;
        chk("mr rst a_rsp_valid", 64'(a_rsp_valid), 64'h0);
        chk("mr rst ram_en", 64'(ram_en), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr idle ram_en", 64'(ram_en), 64'h0);
        chk("mr idle a_rsp_valid", 64'(a_rsp_valid), 64'h0);
        @(negedge clk);
        #1;
        chk("mr no stale a_rsp_valid", 64'(a_rsp_valid), 64'h0);
        a_cmd_valid = 1'b1; a_cmd_addr = 11'h402;
        #1;
        chk("mr restart ready", 64'(a_cmd_ready), 64'h1);
        chk("mr restart addr", 64'(ram_addr), 64'h402);
        @(negedge clk);
        a_cmd_valid = 1'b0;
        #1;
        chk("mr restart beat1 addr", 64'(ram_addr), 64'h403);
        chk("mr restart rsp valid", 64'(a_rsp_valid), 64'h1);
        chk("mr restart rsp data", a_rsp_data, mv(11'h402));

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/internal_ram_arbiter.md
# internal_ram_arbiter

Arbiter/sequencer sharing the single-port 16 KB on-chip RAM (2048 × 64-bit, lower 1024 words ROM, upper 1024 words writable) between an instruction-fetch port (A, read-only, line bursts) and a data port (B, single-beat read/write with byte mask). The arbiter issues at most one RAM access per cycle, keeps A's line bursts atomic, rejects writes to the ROM half with an error response, and returns read data with fixed latency.

## Interface
Parameters:
- `LINE_WORDS`, 4: words per port-A burst; power of two, 2..16.

Ports:
- `clk`  in  1  clock; everything samples on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `a_cmd_valid`  in  1  fetch request.
- `a_cmd_ready`  out  1  fetch request accepted this cycle.
- `a_cmd_addr`  in  11  word address of the critical word.
- `a_rsp_valid`  out  1  fetch data beat valid.
- `a_rsp_data`  out  64  fetch data.
- `a_rsp_last`  out  1  final beat of the burst.
- `b_cmd_valid`  in  1  data request.
- `b_cmd_ready`  out  1  data request accepted this cycle.
- `b_cmd_write`  in  1  1 = write, 0 = read.
- `b_cmd_addr`  in  11  word address.
- `b_cmd_mask`  in  8  byte enables for writes.
- `b_cmd_data`  in  64  write data.
- `b_rsp_valid`  out  1  data response (read data or write ack).
- `b_rsp_data`  out  64  read data; don't-care on writes.
- `b_rsp_error`  out  1  write to ROM half rejected.
- `ram_en`, `ram_wr`  out  1 each  RAM clock enable, write enable.
- `ram_addr`  out  11  RAM word address.
- `ram_mask`  out  8  RAM byte enables.
- `ram_wrData`  out  64  RAM write data.
- `ram_rdData`  in  64  RAM read data, valid one cycle after `ram_en`.

## Operation
- States: IDLE, BURST. Burst beat counter `beat` (log2(LINE_WORDS) bits), `burst_base` (line address), `last_grant` (A/B).
- IDLE: if exactly one `*_cmd_valid`, grant it. If both, grant the port not in `last_grant` (round-robin). `*_cmd_ready` is combinational: high only for the granted port in the same cycle it is valid. Grant updates `last_grant`.
- A granted: issue beat 0 at `a_cmd_addr` in the acceptance cycle; latch the address; go to BURST with `beat` = 1.
- BURST: issue one read per cycle at `{addr[10:k], (addr[k-1:0] + beat) mod LINE_WORDS}`, k = log2(LINE_WORDS) (wrap within line, critical word first). `b_cmd_ready` = 0 and `a_cmd_ready` = 0 throughout. After issuing beat LINE_WORDS-1, return to IDLE.
- B read: `ram_en` = 1, `ram_wr` = 0, address from `b_cmd_addr`.
- B write with `b_cmd_addr[10]` = 1: `ram_en` = `ram_wr` = 1, `ram_mask`/`ram_wrData` from the command. With `b_cmd_addr[10]` = 0 (ROM half): no RAM access (`ram_en` = 0). The command is still accepted and answered with error.
- `ram_en` = 0 on every cycle with no issue. `ram_mask` = 0 and `ram_wr` = 0 on reads.
- Responses cannot be backpressured; requesters always accept them.

## Timing
- Latency: response exactly 1 cycle after acceptance/issue. `a_rsp_data` and `b_rsp_data` are driven from `ram_rdData` in the response cycle.
- A burst: LINE_WORDS consecutive `a_rsp_valid` cycles, the first one cycle after acceptance. `a_rsp_last` is high on the final beat only.
- B: one `b_rsp_valid` per accepted command. `b_rsp_error` = 1 only for ROM-half writes; it is 0 on reads and legal writes.
- Back-to-back: a new grant is possible in the cycle after BURST ends (IDLE). B may be accepted every cycle while A is idle.
- Simultaneous A/B in IDLE: after reset the first tie goes to A (`last_grant` resets to B), then grants alternate.
- Reset (any time, including mid-burst): state = IDLE, `beat` = 0, `last_grant` = B, `a_rsp_valid` = `a_rsp_last` = `b_rsp_valid` = `b_rsp_error` = 0. `ram_en` = `ram_wr` = 0 while reset is asserted. Pending burst beats are dropped; no response is produced for them.
- All RAM control outputs are combinational from state and commands. Response flags are registered.

## Test plan
- A burst at addr 0x402, LINE_WORDS=4 -> ram_addr 0x402, 0x403, 0x400, 0x401 on consecutive cycles; 4 `a_rsp_valid` beats, `a_rsp_last` on the 4th.
- B write addr 0x500, mask 0x0F, data 0x1122334455667788; then read 0x500 -> `ram_wr` pulse; read response carries only the masked bytes updated; `b_rsp_error` = 0.
- B write addr 0x010 -> `ram_en` stays 0; `b_rsp_valid` = 1 with `b_rsp_error` = 1 one cycle later.
- A and B valid together for 3 requests each from reset -> grant order A, B, A, B…; B never accepted during an A burst (ready low LINE_WORDS-1 cycles).
- Reset asserted at burst beat 2 -> `a_rsp_valid` drops immediately, state IDLE, next A request restarts at beat 0.
- Continuous B reads with A idle -> one acceptance and one `b_rsp_valid` per cycle, data matching preloaded ROM contents.
